// File: rtl/kat_adc_pkg.sv
// Shared definitions for the QDR snapshot readback path: FSM encoding,
// QDR word lane layout and the 36-bit to 32-bit unpack helper.
package kat_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A QDR word is four 9-bit lanes; each lane is 8 data bits with the
    // pad bit on top, so pad bits sit at l*LANE_STRIDE + LANE_W = 8/17/26/35.
    localparam int LANES       = 4;
    localparam int LANE_W      = 8;
    localparam int LANE_STRIDE = 9;
    localparam int QDR_WORD_W  = LANES * LANE_STRIDE;
    localparam int OUT_WORD_W  = LANES * LANE_W;

    // Drop the pad bit of every lane and pack the data bytes densely.
    function automatic logic [OUT_WORD_W-1:0] qdr_unpack(input logic [QDR_WORD_W-1:0] din);
        logic [OUT_WORD_W-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            w[l*LANE_W +: LANE_W] = din[l*LANE_STRIDE +: LANE_W];
        end
        return w;
    endfunction

endpackage

// File: rtl/kat_adc_rb_fifo.sv
// Small first-word-fall-through FIFO that buffers unpacked QDR read data
// for the software-facing consumer. The head word is visible on dout the
// cycle after it is pushed; push and pop in the same cycle both take effect.
module kat_adc_rb_fifo #(
    parameter int AW = 4,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;

    // Storage write; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Occupancy bookkeeping for simultaneous push/pop.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + {{AW{1'b0}}, 1'b1};
            2'b01:   count_next = count_reg - {{AW{1'b0}}, 1'b1};
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Depth is tiny, so the head is read straight from storage (distributed RAM).
    assign dout  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/kat_adc_qdr_readback.sv
// Streams a captured ADC snapshot out of one QDR bank into the software
// buffer. Reads are credit-limited so that requests in flight plus words
// already buffered never exceed the FIFO depth.
module kat_adc_qdr_readback
    import kat_adc_pkg::*;
#(
    parameter int QDR_SIZE = 14,
    parameter int FIFO_AW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [QDR_SIZE-1:0] base_addr,
    input  logic [QDR_SIZE:0]   length,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [31:0]         qdr_address,
    output logic                qdr_rd_en,
    output logic                qdr_wr_en,
    output logic [3:0]          qdr_be,
    output logic [35:0]         qdr_dout,
    input  logic [35:0]         qdr_din,
    input  logic                qdr_ack,
    input  logic                qdr_phy_ready,
    input  logic                qdr_cal_fail,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    state_t              state_reg, state_next;
    logic [QDR_SIZE-1:0] base_reg, base_next;
    logic [QDR_SIZE-1:0] addr_reg, addr_next;
    logic [QDR_SIZE:0]   length_reg, length_next;
    logic [QDR_SIZE:0]   issued_reg, issued_next;
    logic [FIFO_AW:0]    outstanding_reg, outstanding_next;
    logic                rd_en_reg, rd_en_next;
    logic                done_reg, done_next;
    logic                error_reg, error_next;

    logic [FIFO_AW:0]    fifo_count;
    logic [FIFO_AW:0]    fifo_count_next;
    logic [FIFO_AW+1:0]  credit_used;
    logic                fifo_empty;
    logic                ack_take;
    logic                pop;
    logic [31:0]         fifo_din;
    logic [31:0]         fifo_dout;

    kat_adc_rb_fifo #(
        .AW (FIFO_AW),
        .W  (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ack_take),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state logic; the read strobe is decided one cycle ahead so it
    // can be registered while still following start by a single cycle.
    always_comb begin
        // Acks in IDLE (late or spurious) and acks with nothing in flight are dropped.
        ack_take         = qdr_ack && (state_reg != ST_IDLE) && (outstanding_reg != '0);
        pop              = out_ready && !fifo_empty;
        fifo_din         = qdr_unpack(qdr_din);
        outstanding_next = outstanding_reg + {{FIFO_AW{1'b0}}, rd_en_reg}
                                           - {{FIFO_AW{1'b0}}, ack_take};
        fifo_count_next  = fifo_count + {{FIFO_AW{1'b0}}, ack_take}
                                      - {{FIFO_AW{1'b0}}, pop};
        issued_next      = issued_reg + {{QDR_SIZE{1'b0}}, rd_en_reg};
        credit_used      = {1'b0, outstanding_next} + {1'b0, fifo_count_next};

        state_next  = state_reg;
        base_next   = base_reg;
        length_next = length_reg;
        addr_next   = addr_reg;
        rd_en_next  = 1'b0;
        done_next   = done_reg;
        error_next  = error_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (qdr_phy_ready && !qdr_cal_fail) begin
                        state_next       = ST_ISSUE;
                        base_next        = base_addr;
                        length_next      = length;
                        addr_next        = base_addr;
                        rd_en_next       = (length != '0);
                        issued_next      = '0;
                        outstanding_next = '0;
                        done_next        = 1'b0;
                        error_next       = 1'b0;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (issued_next == length_reg) begin
                    state_next = ST_DRAIN;
                end else begin
                    // Upper bits clear means total commitment stays below FIFO depth.
                    rd_en_next = (credit_used[FIFO_AW+1:FIFO_AW] == 2'b00);
                    addr_next  = base_reg + issued_next[QDR_SIZE-1:0];
                end
            end
            ST_DRAIN: begin
                if ((outstanding_next == '0) && (fifo_count_next == '0)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            base_reg        <= '0;
            addr_reg        <= '0;
            length_reg      <= '0;
            issued_reg      <= '0;
            outstanding_reg <= '0;
            rd_en_reg       <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            base_reg        <= base_next;
            addr_reg        <= addr_next;
            length_reg      <= length_next;
            issued_reg      <= issued_next;
            outstanding_reg <= outstanding_next;
            rd_en_reg       <= rd_en_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;
    assign error       = error_reg;
    assign qdr_address = {{(32-QDR_SIZE){1'b0}}, addr_reg};
    assign qdr_rd_en   = rd_en_reg;
    assign qdr_wr_en   = 1'b0;
    assign qdr_be      = 4'b1111;
    assign qdr_dout    = '0;
    assign out_data    = fifo_dout;
    assign out_valid   = !fifo_empty;

endmodule

// File: tb/tb_kat_adc_qdr_readback.sv
// Bench for the QDR readback block: a fixed-latency QDR read model with a
// known preload pattern, an output scoreboard fed at start time, and one
// task per scenario.
module tb_kat_adc_qdr_readback;

    localparam int QS  = 14;
    localparam int AW  = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [QS-1:0] base_addr = '0;
    logic [QS:0]   length = '0;
    logic          busy, done, error;
    logic [31:0]   qdr_address;
    logic          qdr_rd_en, qdr_wr_en;
    logic [3:0]    qdr_be;
    logic [35:0]   qdr_dout;
    logic [35:0]   qdr_din;
    logic          qdr_ack;
    logic          qdr_phy_ready = 1'b1;
    logic          qdr_cal_fail = 1'b0;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_count = 0;
    int ack_cnt = 0;
    int pop_cnt = 0;
    int last_pop_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_log[$];

    always #5 clk = ~clk;

    kat_adc_qdr_readback #(.QDR_SIZE(QS), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .error(error),
        .qdr_address(qdr_address), .qdr_rd_en(qdr_rd_en), .qdr_wr_en(qdr_wr_en),
        .qdr_be(qdr_be), .qdr_dout(qdr_dout), .qdr_din(qdr_din), .qdr_ack(qdr_ack),
        .qdr_phy_ready(qdr_phy_ready), .qdr_cal_fail(qdr_cal_fail),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Preload pattern: word a holds bytes {a+3,a+2,a+1,a} with all pad bits set.
    function automatic logic [35:0] pack_word(input logic [QS-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {1'b1, b + 8'd3, 1'b1, b + 8'd2, 1'b1, b + 8'd1, 1'b1, b};
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // QDR read model: ack arrives LAT cycles after the request, in order.
    logic [LAT-1:0] pipe_v = '0;
    logic [QS-1:0]  pipe_a [LAT];
    logic           inj_ack = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe_v <= {pipe_v[LAT-2:0], qdr_rd_en};
        pipe_a[0] <= qdr_address[QS-1:0];
        for (int k = 1; k < LAT; k++) pipe_a[k] <= pipe_a[k-1];
    end

    assign qdr_ack = pipe_v[LAT-1] | inj_ack;
    assign qdr_din = pipe_v[LAT-1] ? pack_word(pipe_a[LAT-1]) : 36'hFFFFFFFFF;

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (qdr_rd_en) begin
            rd_count = rd_count + 1;
            addr_log.push_back(qdr_address);
        end
        if (qdr_ack) ack_cnt = ack_cnt + 1;
        if (out_valid && out_ready) begin
            logic [31:0] e;
            pop_cnt = pop_cnt + 1;
            last_pop_cyc = cyc;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_extra: got %h, required no word", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors = errors + 1;
                    $display("FAIL scoreboard_data: got %h, required %h", out_data, e);
                end
            end
        end
    end

    task automatic do_start(input int b, input int l, input bit push_exp);
        @(negedge clk);
        base_addr = QS'(b);
        length = (QS+1)'(l);
        start = 1'b1;
        if (push_exp) for (int k = 0; k < l; k++) exp_q.push_back(exp_word((b + k) % (1 << QS)));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", error); end
        checks++; if (qdr_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", qdr_rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (qdr_address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %0d required 0", qdr_address); end
        checks++; if ({qdr_wr_en, qdr_be, qdr_dout} !== {1'b0, 4'hF, 36'd0}) begin errors++; $display("FAIL tied_outputs: got wr=%b be=%h dout=%h required 0/f/0", qdr_wr_en, qdr_be, qdr_dout); end
        rst = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_basic;
        bit ok;
        out_ready = 1'b1; rd_count = 0; pop_cnt = 0;
        do_start(0, 8, 1'b1);
        checks++; if (qdr_rd_en !== 1'b1) begin errors++; $display("FAIL basic_first_rd: got %b required 1", qdr_rd_en); end
        checks++; if (qdr_address !== 32'd0) begin errors++; $display("FAIL basic_first_addr: got %0d required 0", qdr_address); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_idle(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: got busy=%b required idle", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b required 1", done); end
        checks++; if (cyc - last_pop_cyc != 1) begin errors++; $display("FAIL basic_busy_drop: got %0d cycles required 1", cyc - last_pop_cyc); end
        checks++; if (pop_cnt != 8) begin errors++; $display("FAIL basic_words: got %0d required 8", pop_cnt); end
        checks++; if (rd_count != 8) begin errors++; $display("FAIL basic_reads: got %0d required 8", rd_count); end
        $display("basic: base=0 length=8 words=%0d", pop_cnt);
    endtask

    task automatic test_wrap;
        bit ok;
        logic [31:0] exp_a [4];
        exp_a = '{32'd16382, 32'd16383, 32'd0, 32'd1};
        addr_log.delete(); pop_cnt = 0;
        do_start(16382, 4, 1'b1);
        wait_idle(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_timeout: got busy=%b required idle", busy); end
        checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d required 4", addr_log.size()); end
        for (int k = 0; k < 4 && k < addr_log.size(); k++) begin
            checks++; if (addr_log[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr%0d: got %0d required %0d", k, addr_log[k], exp_a[k]); end
        end
        checks++; if (pop_cnt != 4) begin errors++; $display("FAIL wrap_words: got %0d required 4", pop_cnt); end
        $display("wrap: base=16382 length=4 reads=%0d", addr_log.size());
    endtask

    task automatic test_backpressure;
        bit ok;
        out_ready = 1'b0; rd_count = 0; pop_cnt = 0;
        do_start(100, 40, 1'b1);
        repeat (60) @(negedge clk);
        checks++; if (rd_count != 16) begin errors++; $display("FAIL bp_stall_reads: got %0d required 16", rd_count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b required 1", busy); end
        out_ready = 1'b1;
        wait_idle(600, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got busy=%b required idle", busy); end
        checks++; if (pop_cnt != 40) begin errors++; $display("FAIL bp_words: got %0d required 40", pop_cnt); end
        checks++; if (rd_count != 40) begin errors++; $display("FAIL bp_reads: got %0d required 40", rd_count); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d required 0", exp_q.size()); end
        $display("backpressure: length=40 words=%0d", pop_cnt);
    endtask

    task automatic test_zero_len;
        int k;
        rd_count = 0;
        do_start(7, 0, 1'b0);
        k = 1;
        while (!done && k < 4) begin
            @(negedge clk);
            k++;
        end
        checks++; if (done !== 1'b1 || k > 3) begin errors++; $display("FAIL zero_done: got done=%b after %0d cycles required 1 within 3", done, k); end
        checks++; if (rd_count != 0) begin errors++; $display("FAIL zero_reads: got %0d required 0", rd_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
        $display("zero_length: done after %0d cycles", k);
    endtask

    task automatic test_error;
        bit ok;
        rd_count = 0;
        qdr_phy_ready = 1'b0;
        do_start(0, 4, 1'b0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_phy: got %b required 1", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b required 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (rd_count != 0) begin errors++; $display("FAIL err_reads: got %0d required 0", rd_count); end
        qdr_phy_ready = 1'b1; qdr_cal_fail = 1'b1;
        do_start(0, 4, 1'b0);
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_cal: got error=%b busy=%b required 1/0", error, busy); end
        qdr_cal_fail = 1'b0; pop_cnt = 0;
        do_start(20, 2, 1'b1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_restart_busy: got %b required 1", busy); end
        wait_idle(300, ok);
        checks++; if (ok !== 1'b1 || done !== 1'b1 || pop_cnt != 2) begin errors++; $display("FAIL err_restart: got ok=%b done=%b words=%0d required 1/1/2", ok, done, pop_cnt); end
        $display("error: phy/cal refused, restart words=%0d", pop_cnt);
    endtask

    task automatic test_reset_abort;
        bit ok;
        int n;
        out_ready = 1'b1; ack_cnt = 0;
        do_start(500, 20, 1'b1);
        n = 0;
        while (ack_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (ack_cnt < 5) begin errors++; $display("FAIL abort_acks: got %0d required 5", ack_cnt); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, error, qdr_rd_en, out_valid} !== 5'b0) begin errors++; $display("FAIL abort_outputs: got %b required 00000", {busy, done, error, qdr_rd_en, out_valid}); end
        checks++; if (qdr_address !== 32'd0) begin errors++; $display("FAIL abort_addr: got %0d required 0", qdr_address); end
        exp_q.delete();
        rst = 1'b0;
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_late_acks: got valid=%b busy=%b required 0/0", out_valid, busy); end
        pop_cnt = 0;
        do_start(0, 4, 1'b1);
        wait_idle(300, ok);
        checks++; if (ok !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL abort_restart: got ok=%b done=%b required 1/1", ok, done); end
        checks++; if (pop_cnt != 4 || exp_q.size() != 0) begin errors++; $display("FAIL abort_restart_words: got %0d left=%0d required 4/0", pop_cnt, exp_q.size()); end
        $display("reset_abort: restart words=%0d", pop_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_error();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kat_adc_qdr_readback.md
Name: kat_adc_qdr_readback

Overview:
Reads a captured ADC snapshot back out of one QDR bank and streams it to the software-facing buffer (BRAM/FIFO bridge) as 32-bit words. It is the read-side counterpart of the capture writer: same QDR controller port, same 4x(1 pad bit + 8 data bits) word packing, same 2^QDR_SIZE-word address space. One instance per QDR bank, driven by its own control/status registers.

Parameters:
QDR_SIZE, 14, QDR word-address width; the capture region is 2^QDR_SIZE words.
FIFO_AW, 4, log2 of the output FIFO depth; FIFO_DEPTH = 2^FIFO_AW = 16 by default.

Ports:
clk  in  1  system clock (QDR controller clock domain)
rst  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse; begins a readback when idle
base_addr  in  QDR_SIZE  first QDR word address, sampled at start
length  in  QDR_SIZE+1  number of words to read, sampled at start; 0 is legal
busy  out  1  high from the cycle after an accepted start until done
done  out  1  sticky; set at completion, cleared by an accepted start or by rst
error  out  1  sticky; start while qdr_phy_ready=0 or qdr_cal_fail=1; cleared by an accepted start or by rst
qdr_address  out  32  zero-extended read address
qdr_rd_en  out  1  read request strobe, 1 cycle per word
qdr_wr_en  out  1  tied 0
qdr_be  out  4  tied 4'b1111
qdr_dout  out  36  tied 0
qdr_din  in  36  read data, valid when qdr_ack=1
qdr_ack  in  1  one pulse per completed read, in request order
qdr_phy_ready  in  1  controller calibrated
qdr_cal_fail  in  1  calibration failed
out_data  out  32  {din[34:27],din[25:18],din[16:9],din[7:0]}
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid and out_ready are both high

Behaviour:
- Reset: state=IDLE; busy, done, error, qdr_rd_en, out_valid = 0; qdr_address = 0; FIFO empty; outstanding count = 0.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE:
  - On start with qdr_phy_ready=1 and qdr_cal_fail=0: latch base_addr and length, clear done and error, reset issued/outstanding counters, go to ISSUE.
  - On start otherwise: set error, stay in IDLE, issue nothing.
  - start is ignored outside IDLE.
- ISSUE:
  - Each cycle, assert qdr_rd_en with qdr_address = (base + issued) mod 2^QDR_SIZE, but only when issued < length and outstanding + fifo_count < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
  - Go to DRAIN when issued == length. length=0 goes to DRAIN immediately with no reads.
- Outstanding counter:
  - +1 on qdr_rd_en, -1 on qdr_ack; both in the same cycle leaves it unchanged.
  - Width FIFO_AW+1 bits.
- Every qdr_ack pushes the unpacked qdr_din into the FIFO in the same cycle. Pad bits 35/26/17/8 are discarded.
- DRAIN: wait until outstanding == 0 and the FIFO is empty. Then set done (sticky), drop busy, go to IDLE.
- busy = (state != IDLE).
- Latency: first qdr_rd_en is 1 cycle after start. A word is available on out_data 1 cycle after its qdr_ack (registered FIFO output).
- Address wrap: base_addr + length > 2^QDR_SIZE wraps to 0 silently. length = 2^QDR_SIZE reads the whole region exactly once.
- qdr_ack while in IDLE (spurious) is dropped; the counter must not underflow.
- Same-cycle FIFO push and pop: both take effect and the count is unchanged. Pop on empty is impossible by construction.
- rst mid-transfer aborts immediately: FIFO flushed, counters cleared. Late acks arriving after reset are dropped per the IDLE rule.
- Mid-transfer, qdr_phy_ready falling does not abort the transfer; it is a software concern.

Decomposition:
- Package kat_adc_pkg: state encoding constants (ST_IDLE, ST_ISSUE, ST_DRAIN), the QDR pad-bit positions, and the unpack function.
- Sub-module kat_adc_rb_fifo: synchronous FWFT FIFO, parameter AW; ports push/din/pop/dout/empty/count.

Test Plan:
1. Preload the QDR model with word i = {i+3,i+2,i+1,i}. start, base=0, length=8, out_ready=1, ack latency 3 -> eight out_data words equal to the preload in order; done=1; busy low 1 cycle after the last pop.
2. base=2^14-2, length=4 -> qdr_address sequence 16382, 16383, 0, 1.
3. out_ready=0, length=40 -> exactly 16 qdr_rd_en pulses and 16 FIFO entries, then stall. Release out_ready -> all 40 words delivered in order, no loss or duplicates.
4. length=0 -> no qdr_rd_en; done asserted within 3 cycles of start.
5. qdr_phy_ready=0 at start -> error=1, busy=0, no reads. Then a valid start clears error.
6. rst asserted after 5 of 20 acks -> all outputs at reset values next cycle. Remaining late acks are ignored. A new start, base=0, length=4, completes correctly.
